// File: rtl/spi_resp_pkg.sv
// Shared types and constants for the SPI responder (spi_slave_resp).
package spi_resp_pkg;
    typedef enum logic {IDLE = 1'b0, SHIFT = 1'b1} resp_state_t;
    localparam int SYNC_STAGES = 2;
    localparam int BYTE_BITS   = 8;
endpackage

// File: rtl/spi_edge_sync.sv
// Multi-flop synchroniser for an async pin, with a one-flop edge detector
// producing single-cycle rise/fall pulses.
module spi_edge_sync
    import spi_resp_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic i_din,
    output logic o_sync,
    output logic o_rise,
    output logic o_fall
);
    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_prev;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync <= '0;
            r_prev <= 1'b0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_din};
            r_prev <= r_sync[SYNC_STAGES-1];
        end
    end

    assign o_sync = r_sync[SYNC_STAGES-1];
    assign o_rise = o_sync & ~r_prev;
    assign o_fall = ~o_sync & r_prev;
endmodule

// File: rtl/spi_slave_resp.sv
// Mode-0 SPI responder with oversampled sclk, bit-count framing and idle timeout.
// Build option: SPI_RESP_LOOPBACK_EN echoes the last received byte on underrun.
module spi_slave_resp
    import spi_resp_pkg::*;
#(
    parameter int          TIMEOUT = 64,
    parameter logic [7:0]  TX_IDLE = 8'hFF
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 sclk,
    input  logic                 MOSI,
    output logic                 MISO,
    input  logic [BYTE_BITS-1:0] tx_data,
    input  logic                 tx_wr,
    output logic                 tx_full,
    output logic [BYTE_BITS-1:0] rx_data,
    output logic                 rx_valid,
    output logic                 busy,
    output logic                 underrun,
    output logic                 frame_err
);
    localparam int TW = $clog2(TIMEOUT + 1);

    resp_state_t            r_state;
    logic [2:0]             r_bit_cnt;
    logic                   r_done;
    logic [TW-1:0]          r_to_cnt;
    logic [BYTE_BITS-1:0]   r_rx_sh;
    logic [BYTE_BITS-1:0]   r_tx_sh;
    logic [BYTE_BITS-1:0]   r_hold;
    logic                   r_loaded;
    logic [SYNC_STAGES-1:0] r_mosi_sync;

    logic                 w_sclk_s, w_rise, w_fall;
    logic                 w_mosi_s;
    logic                 w_xfer, w_wr_ok;
    logic [BYTE_BITS-1:0] w_fill;

    spi_edge_sync u_sclk_sync (
        .clk    (clk),
        .rst    (rst),
        .i_din  (sclk),
        .o_sync (w_sclk_s),
        .o_rise (w_rise),
        .o_fall (w_fall)
    );

    // MOSI gets the same synchroniser depth so it stays aligned with sclk edges.
    always_ff @(posedge clk) begin
        if (rst) r_mosi_sync <= '0;
        else     r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], MOSI};
    end
    assign w_mosi_s = r_mosi_sync[SYNC_STAGES-1];

`ifdef SPI_RESP_LOOPBACK_EN
    assign w_fill = rx_data;
`else
    assign w_fill = TX_IDLE;
`endif

    // Hold moves into the shifter only when the shifter is free and no byte is starting.
    assign w_xfer  = (r_state == IDLE) && tx_full && !r_loaded && !w_rise;
    assign w_wr_ok = tx_wr && (!tx_full || w_xfer);
    assign busy    = (r_state == SHIFT);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= IDLE;
            r_bit_cnt <= '0;
            r_done    <= 1'b0;
            r_to_cnt  <= '0;
            r_rx_sh   <= '0;
            r_tx_sh   <= TX_IDLE;
            r_hold    <= '0;
            r_loaded  <= 1'b0;
            MISO      <= TX_IDLE[7];
            tx_full   <= 1'b0;
            rx_data   <= '0;
            rx_valid  <= 1'b0;
            underrun  <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            rx_valid  <= 1'b0;
            underrun  <= 1'b0;
            frame_err <= 1'b0;
            MISO      <= r_tx_sh[7];

            if (w_wr_ok) begin
                r_hold  <= tx_data;
                tx_full <= 1'b1;
            end else if (w_xfer) begin
                tx_full <= 1'b0;
            end

            case (r_state)
                IDLE: begin
                    r_to_cnt  <= '0;
                    r_bit_cnt <= '0;
                    r_done    <= 1'b0;
                    if (w_rise) begin
                        r_state   <= SHIFT;
                        r_rx_sh   <= {r_rx_sh[6:0], w_mosi_s};
                        r_bit_cnt <= 3'd1;
                        if (!r_loaded) underrun <= 1'b1;
                    end else if (w_xfer) begin
                        r_tx_sh  <= r_hold;
                        r_loaded <= 1'b1;
                    end
                end
                SHIFT: begin
                    if (r_to_cnt == TW'(TIMEOUT)) begin
                        frame_err <= 1'b1;
                        r_rx_sh   <= '0;
                        r_tx_sh   <= w_fill;
                        r_loaded  <= 1'b0;
                        r_bit_cnt <= '0;
                        r_done    <= 1'b0;
                        r_to_cnt  <= '0;
                        r_state   <= IDLE;
                    end else begin
                        r_to_cnt <= (w_rise || w_fall) ? '0 : r_to_cnt + 1'b1;
                        if (w_rise && !r_done) begin
                            r_rx_sh   <= {r_rx_sh[6:0], w_mosi_s};
                            r_bit_cnt <= r_bit_cnt + 3'd1;
                            if (r_bit_cnt == 3'd7) begin
                                rx_data  <= {r_rx_sh[6:0], w_mosi_s};
                                rx_valid <= 1'b1;
                                r_done   <= 1'b1;
                            end
                        end
                        // The fall after the last rise closes the byte.
                        if (w_fall) begin
                            if (r_done) begin
                                r_tx_sh   <= w_fill;
                                r_loaded  <= 1'b0;
                                r_bit_cnt <= '0;
                                r_done    <= 1'b0;
                                r_state   <= IDLE;
                            end else begin
                                r_tx_sh <= {r_tx_sh[6:0], 1'b0};
                            end
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    logic w_unused;
    assign w_unused = w_sclk_s;
endmodule

// File: tb/tb_spi_slave_resp.sv
// Directed bench for spi_slave_resp: acts as a mode-0 SPI master at clk/8.
module tb_spi_slave_resp;
    localparam int TIMEOUT = 64;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       sclk = 1'b0;
    logic       MOSI = 1'b0;
    logic       MISO;
    logic [7:0] tx_data = 8'h00;
    logic       tx_wr = 1'b0;
    logic       tx_full;
    logic [7:0] rx_data;
    logic       rx_valid, busy, underrun, frame_err;

    spi_slave_resp #(.TIMEOUT(TIMEOUT), .TX_IDLE(8'hFF)) dut (
        .clk       (clk),
        .rst       (rst),
        .sclk      (sclk),
        .MOSI      (MOSI),
        .MISO      (MISO),
        .tx_data   (tx_data),
        .tx_wr     (tx_wr),
        .tx_full   (tx_full),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .busy      (busy),
        .underrun  (underrun),
        .frame_err (frame_err)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;
    int n_rxv = 0, n_und = 0, n_fer = 0;
    logic busy_mid;

    always @(posedge clk) begin
        if (rx_valid)  n_rxv <= n_rxv + 1;
        if (underrun)  n_und <= n_und + 1;
        if (frame_err) n_fer <= n_fer + 1;
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wr(input logic [7:0] d);
        tx_data = d;
        tx_wr   = 1'b1;
        tick(1);
        tx_wr   = 1'b0;
    endtask

    // MISO is sampled at the end of each high phase, just before the next fall.
    task automatic spi_byte(input logic [7:0] mo, output logic [7:0] mi, input int nbits);
        mi = 8'h00;
        for (int i = 0; i < nbits; i++) begin
            sclk = 1'b0;
            MOSI = mo[7-i];
            tick(4);
            sclk = 1'b1;
            tick(4);
            if (i == 4) busy_mid = busy;
            mi[7-i] = MISO;
        end
        sclk = 1'b0;
        tick(4);
    endtask

    task automatic check_reset_vals(input string pfx);
        check({pfx, "_miso"},      {31'd0, MISO},      32'd1);
        check({pfx, "_tx_full"},   {31'd0, tx_full},   32'd0);
        check({pfx, "_rx_data"},   {24'd0, rx_data},   32'd0);
        check({pfx, "_rx_valid"},  {31'd0, rx_valid},  32'd0);
        check({pfx, "_busy"},      {31'd0, busy},      32'd0);
        check({pfx, "_underrun"},  {31'd0, underrun},  32'd0);
        check({pfx, "_frame_err"}, {31'd0, frame_err}, 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] mi, mi2, fill_exp;
        int rxv0, und0, fer0;
        fill_exp = 8'hFF;

        // Reset values
        tick(3);
        check_reset_vals("rst");
        rst = 1'b0;
        tick(2);

        // Loaded byte A5 returned while 3C is received
        wr(8'hA5);
        check("wr_full", {31'd0, tx_full}, 32'd1);
        tick(2);
        check("xfer_empty", {31'd0, tx_full}, 32'd0);
        rxv0 = n_rxv; und0 = n_und;
        spi_byte(8'h3C, mi, 8);
        check("t1_miso", {24'd0, mi}, 32'hA5);
        check("t1_rx", {24'd0, rx_data}, 32'h3C);
        check("t1_rxv", n_rxv - rxv0, 1);
        check("t1_und", n_und - und0, 0);
        check("t1_busy_mid", {31'd0, busy_mid}, 32'd1);
        check("t1_busy_end", {31'd0, busy}, 32'd0);
        check("t1_tx_full", {31'd0, tx_full}, 32'd0);
`ifdef SPI_RESP_LOOPBACK_EN
        fill_exp = 8'h3C;
`endif
        tick(4);

        // Underrun: fill byte (or echo) returned
        und0 = n_und;
        spi_byte(8'h00, mi, 8);
        check("t2_miso", {24'd0, mi}, {24'd0, fill_exp});
        check("t2_und", n_und - und0, 1);
        check("t2_rx", {24'd0, rx_data}, 32'h00);
        tick(4);

        // Back-to-back bytes with a write landing mid-byte
        wr(8'hC3);
        tick(3);
        check("t3_loaded", {31'd0, tx_full}, 32'd0);
        rxv0 = n_rxv; und0 = n_und;
        fork
            spi_byte(8'h11, mi, 8);
            begin
                tick(20);
                wr(8'h5A);
                check("t3_hold_full", {31'd0, tx_full}, 32'd1);
            end
        join
        spi_byte(8'h22, mi2, 8);
        check("t3_miso0", {24'd0, mi}, 32'hC3);
        check("t3_miso1", {24'd0, mi2}, 32'h5A);
        check("t3_rxv", n_rxv - rxv0, 2);
        check("t3_und", n_und - und0, 0);
        check("t3_rx", {24'd0, rx_data}, 32'h22);
`ifdef SPI_RESP_LOOPBACK_EN
        fill_exp = 8'h22;
`endif
        tick(4);

        // Second write while full is dropped
        und0 = n_und;
        fork
            spi_byte(8'h00, mi, 8);
            begin
                tick(10);
                wr(8'h01);
                tick(2);
                wr(8'h02);
                check("t4_still_full", {31'd0, tx_full}, 32'd1);
            end
        join
        check("t4_und_miso", {24'd0, mi}, {24'd0, fill_exp});
        check("t4_und", n_und - und0, 1);
        spi_byte(8'h77, mi, 8);
        check("t4_miso", {24'd0, mi}, 32'h01);
        check("t4_rx", {24'd0, rx_data}, 32'h77);
`ifdef SPI_RESP_LOOPBACK_EN
        fill_exp = 8'h77;
`endif
        tick(4);

        // Timeout abort after 4 bits
        rxv0 = n_rxv; fer0 = n_fer;
        spi_byte(8'hF0, mi, 4);
        tick(TIMEOUT + 5);
        check("t5_fer", n_fer - fer0, 1);
        check("t5_rxv", n_rxv - rxv0, 0);
        check("t5_busy", {31'd0, busy}, 32'd0);
        check("t5_rx_kept", {24'd0, rx_data}, 32'h77);
        rxv0 = n_rxv;
        spi_byte(8'h96, mi, 8);
        check("t5_miso", {24'd0, mi}, {24'd0, fill_exp});
        check("t5_rx", {24'd0, rx_data}, 32'h96);
        check("t5_rxv2", n_rxv - rxv0, 1);
        tick(4);

        // Reset mid-byte
        fer0 = n_fer;
        spi_byte(8'hAB, mi, 5);
        rst = 1'b1;
        tick(2);
        check_reset_vals("t6");
        rst = 1'b0;
        fill_exp = 8'hFF;
        tick(TIMEOUT + 10);
        check("t6_no_fer", n_fer - fer0, 0);
        rxv0 = n_rxv;
        spi_byte(8'h5B, mi, 8);
        check("t6_miso", {24'd0, mi}, {24'd0, fill_exp});
        check("t6_rx", {24'd0, rx_data}, 32'h5B);
        check("t6_rxv", n_rxv - rxv0, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
